// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared FSM states, frame field positions and frame builder for dac_spi_multi_ctrl
package dac_spi_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, GAP, LATCH, FINISH} state_t;
  localparam int AB_BIT = 15;
  localparam int BUF_BIT = 14;
  localparam int GA_BIT = 13;
  localparam int SHDN_BIT = 12;
  // Header nibble sits directly above the dw-bit code; field offsets follow the 12-bit layout.
  function automatic logic [31:0] build_frame(input logic ab, input logic [31:0] code, input logic shdn, input logic ga, input int dw);
    logic [3:0] hdr;
    hdr = '0;
    hdr[AB_BIT-SHDN_BIT] = ab;
    hdr[BUF_BIT-SHDN_BIT] = 1'b0;
    hdr[GA_BIT-SHDN_BIT] = ga;
    hdr[0] = ~shdn;
    return ({28'd0, hdr} << dw) | code;
  endfunction
endpackage

// File: rtl/dac_spi_multi_ctrl_sck_gen.sv
// spi_sck_gen: SCK half-period divider, frame bit counter, SCK edge strobes and end-of-frame strobe
// Ports: clk, rst_n (async active-low), en (frame in progress), sck_rise/sck_fall (last cycle
// before SCK goes high/low), frame_done (fall strobe of the last bit), bit_idx (current bit, 0 = MSB).
module spi_sck_gen #(
  parameter int CLK_DIV = 4,
  parameter int FW = 16,
  parameter int BW = $clog2(FW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          sck_rise,
  output logic          sck_fall,
  output logic          frame_done,
  output logic [BW-1:0] bit_idx
);
  localparam int DW = $clog2(CLK_DIV + 1);
  logic [DW-1:0] div;
  logic ph;
  logic last;
  assign last = div == DW'(CLK_DIV - 1);
  assign sck_rise = en && !ph && last;
  assign sck_fall = en && ph && last;
  assign frame_done = sck_fall && bit_idx == BW'(FW - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      ph <= 1'b0;
      bit_idx <= '0;
    end else if (!en) begin
      div <= '0;
      ph <= 1'b0;
      bit_idx <= '0;
    end else begin
      div <= last ? '0 : div + 1'b1;
      ph <= ph ^ last;
      bit_idx <= bit_idx + BW'(sck_fall);
    end
endmodule

// File: rtl/dac_spi_multi_ctrl.sv
// dac_spi_multi_ctrl: shifts one SPI frame per channel to NUM_DEV dual 12-bit DACs, then updates them
// Ports: clk, rst_n (async active-low); sample/sample_valid/sample_ready (packed codes, channel i at
// sample[i*DATA_W +: DATA_W]); ldac_mode (0 sync, 1 transparent, taken at accept); cs_n per device;
// sck, sdi shared SPI bus; ldac_n shared latch; done one-cycle pulse when the set is applied.
// Optional macro DAC_CH_SHDN_EN adds ch_shdn: channels with a 1 are sent with SHDN_N=0.
module dac_spi_multi_ctrl
  import dac_spi_pkg::*;
#(
  parameter int NUM_DEV = 2,
  parameter int DATA_W = 12,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 2,
  parameter int LDAC_W = 2,
  parameter int GAIN_1X = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2*NUM_DEV*DATA_W-1:0] sample,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic                       ldac_mode,
`ifdef DAC_CH_SHDN_EN
  input  logic [2*NUM_DEV-1:0]       ch_shdn,
`endif
  output logic [NUM_DEV-1:0]         cs_n,
  output logic                       sck,
  output logic                       sdi,
  output logic                       ldac_n,
  output logic                       done
);
  localparam int NUM_CH = 2 * NUM_DEV;
  localparam int FW = DATA_W + 4;
  localparam int CH_W = $clog2(NUM_CH);
  localparam int BW = $clog2(FW);
  state_t state, nxt;
  logic [15:0] cnt;
  logic [CH_W-1:0] ch;
  logic [NUM_CH*DATA_W-1:0] sample_q;
  logic mode_q, up, accept, shdn;
  logic sck_rise, sck_fall, frame_done;
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] frame;
  spi_sck_gen #(.CLK_DIV(CLK_DIV), .FW(FW)) u_sck (
    .clk(clk),
    .rst_n(rst_n),
    .en(state == SHIFT),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .frame_done(frame_done),
    .bit_idx(bit_idx)
  );
`ifdef DAC_CH_SHDN_EN
  logic [NUM_CH-1:0] shdn_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shdn_q <= '0;
    else if (accept) shdn_q <= ch_shdn;
  assign shdn = shdn_q[ch];
`else
  assign shdn = 1'b0;
`endif
  assign accept = sample_valid && sample_ready;
  assign frame = FW'(build_frame(ch[0], 32'(sample_q[ch*DATA_W +: DATA_W]), shdn, 1'(GAIN_1X), DATA_W));
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = accept ? SHIFT : IDLE;
      SHIFT: nxt = frame_done ? GAP : SHIFT;
      GAP: nxt = cnt != 16'(CS_GAP - 1) ? GAP : ch != CH_W'(NUM_CH - 1) ? SHIFT : mode_q ? FINISH : LATCH;
      LATCH: nxt = cnt == 16'(LDAC_W - 1) ? FINISH : LATCH;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
      sample_q <= '0;
      mode_q <= 1'b0;
      up <= 1'b0;
      sck <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      ch <= accept ? '0 : (state == GAP && nxt == SHIFT) ? ch + 1'b1 : ch;
      sample_q <= accept ? sample : sample_q;
      mode_q <= accept ? ldac_mode : mode_q;
      up <= 1'b1;
      sck <= sck_rise ? 1'b1 : sck_fall ? 1'b0 : sck;
    end
  assign sample_ready = up && state == IDLE;
  assign cs_n = state == SHIFT ? ~(NUM_DEV'(1) << (ch >> 1)) : '1;
  assign sdi = state == SHIFT && frame[BW'(FW - 1) - bit_idx];
  // Transparent mode keeps the DACs latching each frame as it lands.
  assign ldac_n = !(state == LATCH || (mode_q && (state == SHIFT || state == GAP)));
  assign done = state == FINISH;
endmodule
